// File: rtl/apb_regfile_completer.sv
// APB completer backed by a small register file; the top register is a
// read-only count of error-free transfers. Wait states are fixed by WAIT_CYCLES.
module apb_regfile_completer #(
    parameter logic [31:0] ADDR_BASE   = 32'hA000,
    parameter int          NUM_REGS    = 4,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic        pclk,
    input  logic        preset_n,
    input  logic        psel_i,
    input  logic        penable_i,
    input  logic [31:0] paddr_i,
    input  logic        pwrite_i,
    input  logic [31:0] pwdata_i,
    output logic [31:0] prdata_o,
    output logic        pready_o,
    output logic        pslverr_o,
    output logic [31:0] reg0_o,
    output logic [1:0]  dbg_state_o
);
    // Handshake: a transfer completes on an edge with psel_i=1, penable_i=1 and
    // pready_o=1; dropping psel_i before that edge abandons it with no side effect.

    localparam logic [3:0] CNT_IDX   = 4'(NUM_REGS - 1);
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READY = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  idx_q, idx_d;
    logic        write_q, write_d;
    logic        err_q, err_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] prdata_q, prdata_d;
    logic        pready_q, pready_d;
    logic        pslverr_q, pslverr_d;
    logic [31:0] regs_q [NUM_REGS];
    logic [31:0] regs_d [NUM_REGS];

    // Decode of the live bus address; the 33-bit offset keeps below-base addresses negative.
    logic [32:0] offs;
    logic        in_range;
    logic [3:0]  dec_idx;
    logic        dec_err;

    assign offs     = {1'b0, paddr_i} - {1'b0, ADDR_BASE};
    assign in_range = !offs[32] && (offs < 33'(4 * NUM_REGS));
    assign dec_idx  = offs[5:2];
    assign dec_err  = !in_range || (paddr_i[1:0] != 2'b00) || (pwrite_i && dec_idx == CNT_IDX);

    logic        go_ready;
    logic [3:0]  ld_idx;
    logic        ld_err;
    logic        ld_write;
    logic [31:0] rd_val;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        write_d   = write_q;
        err_d     = err_q;
        wdata_d   = wdata_q;
        prdata_d  = prdata_q;
        pready_d  = pready_q;
        pslverr_d = pslverr_q;
        for (int i = 0; i < NUM_REGS; i++) regs_d[i] = regs_q[i];
        go_ready  = 1'b0;
        ld_idx    = idx_q;
        ld_err    = err_q;
        ld_write  = write_q;
        rd_val    = 32'd0;

        case (state_q)
            ST_IDLE: begin
                if (psel_i && !penable_i) begin
                    idx_d   = dec_idx;
                    err_d   = dec_err;
                    write_d = pwrite_i;
                    wdata_d = pwdata_i;
                    if (WAIT_CYCLES == 0) begin
                        go_ready = 1'b1;
                        ld_idx   = dec_idx;
                        ld_err   = dec_err;
                        ld_write = pwrite_i;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!psel_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else if (penable_i) begin
                    if (cnt_q == 4'd0) go_ready = 1'b1;
                    else               cnt_d = cnt_q - 4'd1;
                end
            end
            ST_READY: begin
                if (!psel_i || (penable_i && pready_q)) begin
                    if (psel_i && !err_q) begin
                        for (int i = 0; i < NUM_REGS - 1; i++)
                            if (write_q && idx_q == 4'(i)) regs_d[i] = wdata_q;
                        regs_d[NUM_REGS-1] = regs_q[NUM_REGS-1] + 32'd1;
                    end
                    state_d   = ST_IDLE;
                    prdata_d  = 32'd0;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Read data is sampled from the register file on the edge that enters ST_READY.
        if (go_ready) begin
            for (int i = 0; i < NUM_REGS; i++)
                if (ld_idx == 4'(i)) rd_val = regs_q[i];
            state_d   = ST_READY;
            cnt_d     = 4'd0;
            pready_d  = 1'b1;
            pslverr_d = ld_err;
            prdata_d  = (!ld_err && !ld_write) ? rd_val : 32'd0;
        end
    end

    always_ff @(posedge pclk) begin
        if (!preset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            idx_q     <= 4'd0;
            write_q   <= 1'b0;
            err_q     <= 1'b0;
            wdata_q   <= 32'd0;
            prdata_q  <= 32'd0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            write_q   <= write_d;
            err_q     <= err_d;
            wdata_q   <= wdata_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
        end
    end

    assign prdata_o    = prdata_q;
    assign pready_o    = pready_q;
    assign pslverr_o   = pslverr_q;
    assign reg0_o      = regs_q[0];
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_apb_regfile_completer.sv
// Bench for apb_regfile_completer: four instances with WAIT_CYCLES 0..3 share one
// APB bus and are selected one at a time; responses go through an expected queue.
module tb_apb_regfile_completer;

    logic        pclk;
    logic        preset_n;
    logic [3:0]  psel;
    logic        penable;
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata [4];
    logic        pready [4];
    logic        pslverr [4];
    logic [31:0] reg0 [4];
    logic [1:0]  dbg_state [4];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        apb_regfile_completer #(
            .ADDR_BASE(32'hA000), .NUM_REGS(4), .WAIT_CYCLES(g)
        ) u_dut (
            .pclk(pclk), .preset_n(preset_n), .psel_i(psel[g]), .penable_i(penable),
            .paddr_i(paddr), .pwrite_i(pwrite), .pwdata_i(pwdata),
            .prdata_o(prdata[g]), .pready_o(pready[g]), .pslverr_o(pslverr[g]),
            .reg0_o(reg0[g]), .dbg_state_o(dbg_state[g])
        );
    end

    // clock / reset
    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int tests_run = 0;
    int tests_failed = 0;
    logic [32:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // driver: SETUP then ACCESS until pready; leaves psel/penable high on return
    task automatic apb_xfer(input int d, input logic [31:0] addr, input logic wr,
                            input logic [31:0] wd, input logic exp_err,
                            input logic [31:0] exp_rd);
        int waits;
        logic [32:0] e;
        exp_q.push_back({exp_err, exp_rd});
        @(posedge pclk); #1;
        psel = '0; psel[d] = 1'b1; penable = 1'b0;
        paddr = addr; pwrite = wr; pwdata = wd;
        @(posedge pclk); #1;
        penable = 1'b1;
        waits = 0;
        while (!pready[d] && waits < 40) begin
            check("prdata_during_wait", prdata[d], 32'd0);
            waits++;
            @(posedge pclk); #1;
        end
        check("wait_states", 32'(waits), 32'(d));
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check("pready", {31'd0, pready[d]}, 32'd1);
            check("pslverr", {31'd0, pslverr[d]}, {31'd0, e[32]});
            check("prdata", prdata[d], e[31:0]);
        end
    endtask

    // completes the current transfer on the next edge and checks outputs clear
    task automatic apb_idle(input int d, input logic [31:0] exp_reg0);
        @(posedge pclk); #1;
        psel = '0; penable = 1'b0;
        check("pready_after", {31'd0, pready[d]}, 32'd0);
        check("pslverr_after", {31'd0, pslverr[d]}, 32'd0);
        check("prdata_after", prdata[d], 32'd0);
        check("reg0", reg0[d], exp_reg0);
        check("state_idle", {30'd0, dbg_state[d]}, 32'd0);
    endtask

    typedef struct {
        int          dut;
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
        logic [31:0] reg0;
    } vec_t;

    vec_t vecs [18];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1, 32'hA000, 1'b1, 32'h5,        1'b0, 32'h0,        32'h5};
        vecs[1]  = '{1, 32'hA00C, 1'b0, 32'h0,        1'b0, 32'h1,        32'h5};
        vecs[2]  = '{0, 32'hA000, 1'b1, 32'h5,        1'b0, 32'h0,        32'h5};
        vecs[3]  = '{0, 32'hA000, 1'b0, 32'h0,        1'b0, 32'h5,        32'h5};
        vecs[4]  = '{3, 32'hA000, 1'b1, 32'h5,        1'b0, 32'h0,        32'h5};
        vecs[5]  = '{3, 32'hA000, 1'b0, 32'h0,        1'b0, 32'h5,        32'h5};
        vecs[6]  = '{1, 32'hA00C, 1'b1, 32'h1234,     1'b1, 32'h0,        32'h5};
        vecs[7]  = '{1, 32'hA010, 1'b0, 32'h0,        1'b1, 32'h0,        32'h5};
        vecs[8]  = '{1, 32'hA002, 1'b1, 32'h77,       1'b1, 32'h0,        32'h5};
        vecs[9]  = '{1, 32'hA00C, 1'b0, 32'h0,        1'b0, 32'h2,        32'h5};
        vecs[10] = '{1, 32'hA000, 1'b0, 32'h0,        1'b0, 32'h5,        32'h5};
        vecs[11] = '{1, 32'hA004, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0,        32'h5};
        vecs[12] = '{1, 32'hA004, 1'b0, 32'h0,        1'b0, 32'hDEADBEEF, 32'h5};
        vecs[13] = '{1, 32'h9FFC, 1'b0, 32'h0,        1'b1, 32'h0,        32'h5};
        vecs[14] = '{1, 32'hA00C, 1'b0, 32'h0,        1'b0, 32'h6,        32'h5};
        vecs[15] = '{2, 32'hA008, 1'b1, 32'hCAFEF00D, 1'b0, 32'h0,        32'h0};
        vecs[16] = '{2, 32'hA008, 1'b0, 32'h0,        1'b0, 32'hCAFEF00D, 32'h0};
        vecs[17] = '{2, 32'hA001, 1'b0, 32'h0,        1'b1, 32'h0,        32'h0};

        preset_n = 1'b0; psel = '0; penable = 1'b0;
        paddr = '0; pwrite = 1'b0; pwdata = '0;
        repeat (2) @(posedge pclk);
        #1;
        for (int d = 0; d < 4; d++) begin
            check("rst_pready", {31'd0, pready[d]}, 32'd0);
            check("rst_prdata", prdata[d], 32'd0);
            check("rst_pslverr", {31'd0, pslverr[d]}, 32'd0);
            check("rst_reg0", reg0[d], 32'd0);
        end
        preset_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            apb_xfer(vecs[i].dut, vecs[i].addr, vecs[i].wr, vecs[i].wdata,
                     vecs[i].err, vecs[i].rdata);
            apb_idle(vecs[i].dut, vecs[i].reg0);
        end

        // back-to-back read then write on the one-wait instance (count is 7 here)
        apb_xfer(1, 32'hA000, 1'b0, 32'h0, 1'b0, 32'h5);
        apb_xfer(1, 32'hA000, 1'b1, 32'h6, 1'b0, 32'h0);
        apb_idle(1, 32'h6);
        apb_xfer(1, 32'hA00C, 1'b0, 32'h0, 1'b0, 32'h9);
        apb_idle(1, 32'h6);

        // abort during the second wait cycle of a write (two-wait instance, count is 2)
        @(posedge pclk); #1;
        psel = '0; psel[2] = 1'b1; penable = 1'b0;
        paddr = 32'hA004; pwrite = 1'b1; pwdata = 32'h9;
        @(posedge pclk); #1;
        penable = 1'b1;
        check("abort_wait1_pready", {31'd0, pready[2]}, 32'd0);
        @(posedge pclk); #1;
        check("abort_wait2_pready", {31'd0, pready[2]}, 32'd0);
        psel = '0; penable = 1'b0;
        @(posedge pclk); #1;
        check("abort_state", {30'd0, dbg_state[2]}, 32'd0);
        check("abort_pready", {31'd0, pready[2]}, 32'd0);
        apb_xfer(2, 32'hA004, 1'b0, 32'h0, 1'b0, 32'h0);
        apb_idle(2, 32'h0);
        apb_xfer(2, 32'hA00C, 1'b0, 32'h0, 1'b0, 32'h3);
        apb_idle(2, 32'h0);

        // reset in the middle of a write on the one-wait instance
        @(posedge pclk); #1;
        psel = '0; psel[1] = 1'b1; penable = 1'b0;
        paddr = 32'hA000; pwrite = 1'b1; pwdata = 32'hBAD;
        @(posedge pclk); #1;
        penable = 1'b1;
        check("mid_state_wait", {30'd0, dbg_state[1]}, 32'd1);
        preset_n = 1'b0;
        @(posedge pclk); #1;
        check("mrst_pready", {31'd0, pready[1]}, 32'd0);
        check("mrst_prdata", prdata[1], 32'd0);
        check("mrst_pslverr", {31'd0, pslverr[1]}, 32'd0);
        check("mrst_reg0", reg0[1], 32'd0);
        check("mrst_reg0_other", reg0[0], 32'd0);
        check("mrst_state", {30'd0, dbg_state[1]}, 32'd0);
        preset_n = 1'b1;
        // ACCESS without SETUP while idle must be ignored
        @(posedge pclk); #1;
        check("violation_state", {30'd0, dbg_state[1]}, 32'd0);
        check("violation_pready", {31'd0, pready[1]}, 32'd0);
        psel = '0; penable = 1'b0;
        apb_xfer(1, 32'hA00C, 1'b0, 32'h0, 1'b0, 32'h0);
        apb_idle(1, 32'h0);
        apb_xfer(1, 32'hA000, 1'b0, 32'h0, 1'b0, 32'h0);
        apb_idle(1, 32'h0);
        apb_xfer(0, 32'hA00C, 1'b0, 32'h0, 1'b0, 32'h0);
        apb_idle(0, 32'h0);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
